// File: rtl/wasm_instr_loader_if.sv
// Byte-stream in, instruction-memory write port out, plus load status, as one bundle.
// Latency: none, wires only.
// Backpressure: stream side via o_byte_rdy, write side via i_wr_rdy.
interface wasm_instr_loader_if #(
  parameter int WR_BYTES = 4,
  parameter int LOG_WIN  = 2,
  parameter int CNT_W    = 11
);
  // byte stream from the host
  logic                   i_start;
  logic                   i_byte_vld;
  logic [7:0]             i_byte;
  logic                   i_byte_last;
  logic                   o_byte_rdy;
  // write port towards the instruction memory controller
  logic                   o_we;
  logic [8*WR_BYTES-1:0]  o_wr_data;
  logic [LOG_WIN-1:0]     o_write_pointer_shift_minusone;
  logic                   i_wr_rdy;
  // load status
  logic                   o_cpu_hold;
  logic                   o_load_done;
  logic                   o_load_error;
  logic [CNT_W-1:0]       o_byte_count;

  // host / memory side: drives the stream and the write acknowledge
  modport master (
    output i_start, i_byte_vld, i_byte, i_byte_last, i_wr_rdy,
    input  o_byte_rdy, o_we, o_wr_data, o_write_pointer_shift_minusone,
           o_cpu_hold, o_load_done, o_load_error, o_byte_count
  );

  // loader side
  modport slave (
    input  i_start, i_byte_vld, i_byte, i_byte_last, i_wr_rdy,
    output o_byte_rdy, o_we, o_wr_data, o_write_pointer_shift_minusone,
           o_cpu_hold, o_load_done, o_load_error, o_byte_count
  );
endinterface

// File: rtl/wasm_instr_loader.sv
// Packs a WASM code byte stream into WR_BYTES-wide instruction-memory writes; holds the core until a clean load.
// Latency: beat-completing byte at edge n -> o_we high in cycle n+1; peak WR_BYTES bytes per WR_BYTES+1 cycles.
// Backpressure: o_byte_rdy drops while a beat waits for i_wr_rdy; beat data/shift held stable until accepted.
// Optional WASM_LOADER_HDR_CHECK_EN: checks and strips the 8-byte module header (magic + version 1).
module wasm_instr_loader #(
  parameter int WR_BYTES  = 4,
  parameter int LOG_WIN   = 2,
  parameter int MAX_BYTES = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  wasm_instr_loader_if.slave   bus
);

  localparam int K_W = LOG_WIN + 1;

`ifdef WASM_LOADER_HDR_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_COLLECT, S_WRITE, S_DONE, S_ERR} state_t;
  // header byte i sits in bits [8i+7:8i]: 00 61 73 6D 01 00 00 00
  localparam logic [63:0] HDR_MAGIC = 64'h0000_0001_6D73_6100;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  state_t                       state;
  state_t                       state_nxt;
  logic [WR_BYTES-1:0][7:0]     beat;
  logic [K_W-1:0]               lane_cnt;
  logic                         beat_last;
  logic [CNT_W-1:0]             byte_count;
  logic                         byte_rdy;
  logic                         byte_acc;
  logic                         start_ok;
  logic                         cap_hit;
  logic [CNT_W:0]               fill_level;

`ifdef WASM_LOADER_HDR_CHECK_EN
  logic [2:0]                   hdr_idx;
  logic                         hdr_match;
  assign hdr_match = (bus.i_byte == HDR_MAGIC[{hdr_idx, 3'b000} +: 8]);
`endif

  // A start is only taken when no load is in flight.
  assign start_ok = bus.i_start &&
                    ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  // Memory is full once written bytes plus buffered lanes reach capacity.
  assign fill_level = {1'b0, byte_count} + (CNT_W+1)'(lane_cnt);
  assign cap_hit    = (fill_level == (CNT_W+1)'(MAX_BYTES));

  // Ready depends on state only, so it never sees same-cycle i_start.
  always_comb begin
    byte_rdy = 1'b0;
    case (state)
`ifdef WASM_LOADER_HDR_CHECK_EN
      S_HDR:     byte_rdy = 1'b1;
`endif
      S_COLLECT: byte_rdy = (lane_cnt < K_W'(WR_BYTES));
      default:   byte_rdy = 1'b0;
    endcase
  end

  assign byte_acc = bus.i_byte_vld && byte_rdy;

  // Load sequencing: header check, collect, write, and terminal states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.i_start) begin
`ifdef WASM_LOADER_HDR_CHECK_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_COLLECT;
`endif
        end
      end
`ifdef WASM_LOADER_HDR_CHECK_EN
      S_HDR: begin
        if (byte_acc) begin
          if (!hdr_match || bus.i_byte_last) state_nxt = S_ERR;
          else if (hdr_idx == 3'd7)          state_nxt = S_COLLECT;
        end
      end
`endif
      S_COLLECT: begin
        if (byte_acc) begin
          if (cap_hit)
            state_nxt = S_ERR;
          else if ((lane_cnt == K_W'(WR_BYTES - 1)) || bus.i_byte_last)
            state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.i_wr_rdy) state_nxt = beat_last ? S_DONE : S_COLLECT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Lane packing, beat release and written-byte accounting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat       <= '0;
      lane_cnt   <= '0;
      beat_last  <= 1'b0;
      byte_count <= '0;
    end else if (start_ok) begin
      beat       <= '0;
      lane_cnt   <= '0;
      beat_last  <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (byte_acc) begin
            if (cap_hit) begin
              // overflow byte is swallowed and the partial beat is dropped
              beat      <= '0;
              lane_cnt  <= '0;
              beat_last <= 1'b0;
            end else begin
              beat[lane_cnt[LOG_WIN-1:0]] <= bus.i_byte;
              lane_cnt  <= lane_cnt + K_W'(1);
              beat_last <= bus.i_byte_last;
            end
          end
        end
        S_WRITE: begin
          if (bus.i_wr_rdy) begin
            byte_count <= byte_count + CNT_W'(lane_cnt);
            beat       <= '0;
            lane_cnt   <= '0;
            beat_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WASM_LOADER_HDR_CHECK_EN
  // Position within the 8-byte module header.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                           hdr_idx <= '0;
    else if (start_ok)                   hdr_idx <= '0;
    else if (state == S_HDR && byte_acc) hdr_idx <= hdr_idx + 3'd1;
  end
`endif

  // Write port and status are pure decodes of registered state.
  assign bus.o_byte_rdy   = byte_rdy;
  assign bus.o_we         = (state == S_WRITE);
  assign bus.o_wr_data    = (state == S_WRITE) ? beat : '0;
  assign bus.o_write_pointer_shift_minusone =
      (state == S_WRITE) ? LOG_WIN'(lane_cnt - K_W'(1)) : '0;
  assign bus.o_cpu_hold   = (state != S_DONE);
  assign bus.o_load_done  = (state == S_DONE);
  assign bus.o_load_error = (state == S_ERR);
  assign bus.o_byte_count = byte_count;

endmodule

// File: doc/wasm_instr_loader.md
# wasm_instr_loader

Byte-stream instruction loader that fills the instruction memory of the WASM core through the write port of the instruction memory controller. It is the writer-side counterpart of the instruction fetch path. It accepts a WASM code byte stream over a valid/ready handshake and packs bytes into write beats of `WR_BYTES` bytes. It drives the write enable, write data and write-window shift count, and holds the core in halt until a load completes without error.

## Interface
Parameters:
- `WR_BYTES`, 4: bytes per write beat; write data width is 8*WR_BYTES.
- `LOG_WIN`, 2: width of the shift count; equals log2(WR_BYTES).
- `MAX_BYTES`, 1024: instruction memory capacity in bytes.
- `CNT_W`, 11: byte counter width; must hold MAX_BYTES.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle pulse that begins a load.
- `i_byte_vld`  in  1  input byte valid.
- `i_byte`  in  8  input byte.
- `i_byte_last`  in  1  marks the final byte of the stream.
- `o_byte_rdy`  out  1  loader accepts a byte this cycle.
- `o_we`  out  1  write request to the instruction memory.
- `o_wr_data`  out  8*WR_BYTES  packed beat; first byte in bits [7:0].
- `o_write_pointer_shift_minusone`  out  LOG_WIN  number of valid bytes in the beat, minus one.
- `i_wr_rdy`  in  1  memory accepts the beat; a transfer occurs when o_we && i_wr_rdy.
- `o_cpu_hold`  out  1  holds the core halted.
- `o_load_done`  out  1  level; the last load completed successfully.
- `o_load_error`  out  1  level; the last load aborted.
- `o_byte_count`  out  CNT_W  bytes written to memory in the current or last load.

## Operation
States and transitions:
- IDLE: start with i_start → HDR if the macro is defined, otherwise → COLLECT.
- HDR: receives the header → COLLECT, or → ERR.
- COLLECT: collects bytes → WRITE.
- WRITE: delivers the beat → COLLECT, or → DONE on the last beat.
- DONE and ERR: i_start → new load.

Start behaviour:
- i_start is honoured only in IDLE, DONE or ERR; it is ignored in every other state.
- On start: byte_count, the lane index and the buffer are cleared, o_load_done and o_load_error are cleared, and o_cpu_hold is set.

Byte acceptance and packing:
- A byte is accepted when i_byte_vld && o_byte_rdy.
- o_byte_rdy = 1 only in HDR, or in COLLECT with the buffer not full.
- Each accepted byte is written into lane index k, and k is incremented.
- A beat is formed when k reaches WR_BYTES, or when a byte with i_byte_last is accepted.

Beat transfer:
- Unused upper lanes of a partial beat are zero.
- shift_minusone = valid bytes - 1.
- In WRITE, o_we stays high and o_wr_data / shift are held stable until i_wr_rdy.
- A transfer adds the beat's valid byte count to byte_count and clears the buffer.
- The transfer goes to DONE if the beat contained the last byte, otherwise back to COLLECT.

Capacity and end of load:
- Overflow: a byte accepted while (byte_count + k) == MAX_BYTES is consumed and discarded. The state goes to ERR, the buffered partial beat is dropped, and no further writes occur.
- DONE: o_load_done = 1 and o_cpu_hold = 0.
- ERR: o_load_error = 1 and o_cpu_hold stays 1. o_byte_rdy = 0 in both DONE and ERR.
- i_byte_last on a byte that also fills the beat produces a single beat, with shift = WR_BYTES-1.

## Timing
Reset values:
- o_cpu_hold = 1. The core stays held from reset until the first successful load.
- All other outputs are 0. The state is IDLE.

Latency:
- The byte that completes a beat is accepted at edge n.
- o_we is registered high in cycle n+1; o_byte_rdy is low from cycle n+1.
- A transfer at edge m returns to COLLECT with o_byte_rdy = 1 in cycle m+1.
- The final transfer at edge m asserts o_load_done and deasserts o_cpu_hold in cycle m+1.
- Peak throughput is WR_BYTES bytes per WR_BYTES+1 cycles.

Reset and simultaneous events:
- i_rst asserted mid-load aborts immediately. The outputs return to reset values, and any pending beat is lost, never written.
- An i_byte_vld arriving with i_start in IDLE is not accepted; o_byte_rdy is 0 in that cycle.

## Configuration
- `WASM_LOADER_HDR_CHECK_EN` defined:
  - The first 8 stream bytes must equal 00 61 73 6D 01 00 00 00 (magic plus version 1).
  - These bytes are consumed in HDR and are neither written nor counted.
  - The first mismatching byte → ERR.
  - i_byte_last inside the header → ERR.
- Macro undefined: the HDR state does not exist, and every byte is instruction payload.

## Test plan
- Start; bytes 01..08, last on 08; i_wr_rdy = 1 → two writes, 0x04030201 and 0x08070605, each with shift = 3. byte_count = 8, o_load_done = 1, o_cpu_hold = 0.
- Start; bytes 01..06, last on 06 → writes 0x04030201 (shift 3) and 0x00000605 (shift 1). byte_count = 6.
- i_wr_rdy held low for 5 cycles during a beat → o_we stays 1, data and shift stay stable, o_byte_rdy = 0. On release, exactly one transfer and no byte loss.
- MAX_BYTES = 8; 9 bytes sent → exactly 2 writes, o_load_error = 1, o_cpu_hold = 1, o_load_done = 0.
- Macro defined: header with byte 3 = 0x6E → ERR with zero writes. A correct header plus AA BB CC DD (last) → one write 0xDDCCBBAA, byte_count = 4.
- i_rst asserted after 3 bytes → all outputs at reset values. A following start plus 4 bytes → one clean write and DONE.
